// File: rtl/imu_filter.sv
// imu_filter: per-channel EMA over 80-bit IMU burst frames, one channel per cycle.
// Optional gyro bias calibration is built when IMU_FILTER_BIAS_EN is defined.
module imu_filter #(
  parameter int unsigned ALPHA_SHIFT = 2,
  parameter int unsigned CAL_LOG2    = 4
) (
  input  logic        hz100,
  input  logic        n_rst,
  input  logic        clk_en,
  input  logic        data_ready,
  input  logic [79:0] data_in,
  output logic        filter_ready,
  output logic        filt_valid,
  output logic [79:0] filt_data,
  output logic        bias_done
);

  localparam int          NCH    = 5;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_PROC, ST_DONE} state_t;

  // Reject out-of-range gain or calibration length at elaboration.
  if (ALPHA_SHIFT > 7 || CAL_LOG2 > 8) begin : g_param_chk
    $error("imu_filter: ALPHA_SHIFT must be 0..7 and CAL_LOG2 0..8");
  end

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [79:0]                frame_q, frame_d;
  logic signed [WORD_W-1:0]   ema_q [NCH];
  logic signed [WORD_W-1:0]   ema_d [NCH];
  logic                       seeded_q, seeded_d;
  logic                       filter_ready_q, filter_ready_d;
  logic                       filt_valid_q, filt_valid_d;
  logic [79:0]                filt_data_q, filt_data_d;

  logic [WORD_W-1:0]          x_raw;
  logic signed [WORD_W-1:0]   x_cur, y_cur, y_new;
  logic signed [WORD_W:0]     diff, step;
  logic                       seed_c, zero_c;

`ifdef IMU_FILTER_BIAS_EN
  localparam int unsigned CNT_W      = CAL_LOG2 + 1;
  localparam int unsigned CAL_FRAMES = 1 << CAL_LOG2;

  logic [CNT_W-1:0]           cal_cnt_q, cal_cnt_d;
  logic signed [23:0]         sum_gx_q, sum_gx_d, sum_gy_q, sum_gy_d;
  logic                       bias_done_q, bias_done_d;
  logic                       gyro_seeded_q, gyro_seeded_d;
  logic [WORD_W-1:0]          bias_gx, bias_gy, bias_w;
  logic [WORD_W:0]            corr;

  // Bias is the mean of the calibration sums; sums freeze once calibration ends.
  assign bias_gx   = WORD_W'(sum_gx_q >>> CAL_LOG2);
  assign bias_gy   = WORD_W'(sum_gy_q >>> CAL_LOG2);
  assign bias_done = bias_done_q;
`else
  assign bias_done = 1'b1;
`endif

  // Next-state, EMA datapath and registered-output decode.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    frame_d        = frame_q;
    ema_d          = ema_q;
    seeded_d       = seeded_q;
    filter_ready_d = filter_ready_q;
    filt_valid_d   = 1'b0;
    filt_data_d    = filt_data_q;
    x_raw          = '0;
    y_cur          = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx_q == IDX_W'(k)) begin
        x_raw = frame_q[WORD_W*(NCH-1-k) +: WORD_W];
        y_cur = ema_q[k];
      end
    end
    x_cur  = x_raw;
    seed_c = !seeded_q;
    zero_c = 1'b0;
`ifdef IMU_FILTER_BIAS_EN
    cal_cnt_d     = cal_cnt_q;
    sum_gx_d      = sum_gx_q;
    sum_gy_d      = sum_gy_q;
    bias_done_d   = bias_done_q;
    gyro_seeded_d = gyro_seeded_q;
    bias_w        = (idx_q == IDX_W'(3)) ? bias_gx : bias_gy;
    corr          = {x_raw[15], x_raw} - {bias_w[15], bias_w};
    if (idx_q >= IDX_W'(3)) begin
      if (!bias_done_q) begin
        zero_c = 1'b1;
      end else begin
        if (corr[16] != corr[15]) x_cur = corr[16] ? 16'sh8000 : 16'sh7FFF;
        else                      x_cur = corr[15:0];
        seed_c = !gyro_seeded_q;
      end
    end
`endif
    diff = {x_cur[15], x_cur} - {y_cur[15], y_cur};
    step = diff >>> ALPHA_SHIFT;
    if (zero_c)      y_new = '0;
    else if (seed_c) y_new = x_cur;
    else             y_new = WORD_W'({y_cur[15], y_cur} + step);

    case (state_q)
      ST_IDLE: begin
        filter_ready_d = 1'b1;
        if (data_ready) begin
          frame_d        = data_in;
          idx_d          = '0;
          state_d        = ST_PROC;
          filter_ready_d = 1'b0;
        end
      end
      ST_PROC: begin
        for (int k = 0; k < NCH; k++) begin
          if (idx_q == IDX_W'(k)) ema_d[k] = y_new;
        end
`ifdef IMU_FILTER_BIAS_EN
        if (!bias_done_q) begin
          if (idx_q == IDX_W'(3)) sum_gx_d = sum_gx_q + {{8{x_raw[15]}}, x_raw};
          if (idx_q == IDX_W'(4)) sum_gy_d = sum_gy_q + {{8{x_raw[15]}}, x_raw};
        end
`endif
        if (idx_q == IDX_W'(NCH-1)) begin
          state_d      = ST_DONE;
          idx_d        = '0;
          seeded_d     = 1'b1;
          filt_valid_d = 1'b1;
          filt_data_d  = {ema_d[0], ema_d[1], ema_d[2], ema_d[3], ema_d[4]};
`ifdef IMU_FILTER_BIAS_EN
          if (!bias_done_q) begin
            cal_cnt_d = cal_cnt_q + CNT_W'(1);
            if (cal_cnt_q == CNT_W'(CAL_FRAMES - 1)) bias_done_d = 1'b1;
          end else begin
            gyro_seeded_d = 1'b1;
          end
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        state_d        = ST_IDLE;
        filter_ready_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; everything holds while clk_en is low.
  always_ff @(posedge hz100 or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      frame_q        <= '0;
      for (int k = 0; k < NCH; k++) ema_q[k] <= '0;
      seeded_q       <= 1'b0;
      filter_ready_q <= 1'b1;
      filt_valid_q   <= 1'b0;
      filt_data_q    <= '0;
`ifdef IMU_FILTER_BIAS_EN
      cal_cnt_q      <= '0;
      sum_gx_q       <= '0;
      sum_gy_q       <= '0;
      bias_done_q    <= 1'b0;
      gyro_seeded_q  <= 1'b0;
`endif
    end else if (clk_en) begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      frame_q        <= frame_d;
      ema_q          <= ema_d;
      seeded_q       <= seeded_d;
      filter_ready_q <= filter_ready_d;
      filt_valid_q   <= filt_valid_d;
      filt_data_q    <= filt_data_d;
`ifdef IMU_FILTER_BIAS_EN
      cal_cnt_q      <= cal_cnt_d;
      sum_gx_q       <= sum_gx_d;
      sum_gy_q       <= sum_gy_d;
      bias_done_q    <= bias_done_d;
      gyro_seeded_q  <= gyro_seeded_d;
`endif
    end
  end

  assign filter_ready = filter_ready_q;
  assign filt_valid   = filt_valid_q;
  assign filt_data    = filt_data_q;

endmodule

// File: tb/tb_imu_filter.sv
// Directed bench for imu_filter (ALPHA_SHIFT=2, CAL_LOG2=4).
module tb_imu_filter;

  logic        hz100 = 1'b0;
  logic        n_rst;
  logic        clk_en;
  logic        data_ready;
  logic [79:0] data_in;
  logic        filter_ready;
  logic        filt_valid;
  logic [79:0] filt_data;
  logic        bias_done;

  int vectors     = 0;
  int miscompares = 0;

`ifdef IMU_FILTER_BIAS_EN
  localparam logic [79:0] MASK   = {48'hFFFF_FFFF_FFFF, 32'h0};
  localparam logic        EXP_BD = 1'b0;
`else
  localparam logic [79:0] MASK   = {80{1'b1}};
  localparam logic        EXP_BD = 1'b1;
`endif

  imu_filter #(.ALPHA_SHIFT(2), .CAL_LOG2(4)) dut (
    .hz100       (hz100),
    .n_rst       (n_rst),
    .clk_en      (clk_en),
    .data_ready  (data_ready),
    .data_in     (data_in),
    .filter_ready(filter_ready),
    .filt_valid  (filt_valid),
    .filt_data   (filt_data),
    .bias_done   (bias_done)
  );

  always #5 hz100 = ~hz100;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [79:0] mk(input logic [15:0] ax, input logic [15:0] ay,
                                     input logic [15:0] az, input logic [15:0] gx,
                                     input logic [15:0] gy);
    return {ax, ay, az, gx, gy};
  endfunction

  task automatic tick();
    @(posedge hz100);
    #1;
  endtask

  // Issue one frame and wait (bounded) for its filt_valid pulse.
  task automatic run_frame(input logic [79:0] d, input int gate_at, input int inj_at,
                           output logic [79:0] q, output int lat, output int waited,
                           output logic rdy_err);
    waited = 0;
    while (filter_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    data_in    = d;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    lat        = 1;
    rdy_err    = filter_ready;
    while (filt_valid !== 1'b1 && lat < 30) begin
      if (gate_at > 0 && lat == gate_at)     clk_en = 1'b0;
      if (gate_at > 0 && lat == gate_at + 3) clk_en = 1'b1;
      if (lat == inj_at) begin
        data_ready = 1'b1;
        data_in    = ~d;
      end else begin
        data_ready = 1'b0;
      end
      tick();
      lat++;
      rdy_err = rdy_err | filter_ready;
    end
    data_ready = 1'b0;
    clk_en     = 1'b1;
    q          = filt_data;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; clk_en = 1'b1; data_ready = 1'b0; data_in = '0;
    repeat (3) tick();
    vectors++;
    if (filter_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", filter_ready); end
    vectors++;
    if (filt_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", filt_valid); end
    vectors++;
    if (filt_data !== 80'h0) begin miscompares++; $display("FAIL reset_data got=%h exp=0", filt_data); end
    vectors++;
    if (bias_done !== EXP_BD) begin miscompares++; $display("FAIL reset_bias_done got=%b exp=%b", bias_done, EXP_BD); end
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (filter_ready !== 1'b1 || filt_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_quiet cyc=%0d ready=%b valid=%b exp ready=1 valid=0", i, filter_ready, filt_valid);
      end
    end
  endtask

  task automatic test_seed_step();
    logic [79:0] din [3];
    logic [79:0] exp [3];
    logic [79:0] q;
    int lat, waited;
    logic rdy_err;
    din[0] = mk(0, 0, 0, 0, 0);   exp[0] = mk(0, 0, 0, 0, 0);
    din[1] = mk(100, 0, 0, 0, 0); exp[1] = mk(25, 0, 0, 0, 0);
    din[2] = mk(100, 0, 0, 0, 0); exp[2] = mk(43, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      run_frame(din[i], 0, 0, q, lat, waited, rdy_err);
      vectors++;
      if (lat !== 6) begin miscompares++; $display("FAIL seed_latency f=%0d got=%0d exp=6", i, lat); end
      vectors++;
      if (rdy_err !== 1'b0) begin miscompares++; $display("FAIL seed_ready_low f=%0d got=%b exp=0", i, rdy_err); end
      vectors++;
      if ((q & MASK) !== (exp[i] & MASK)) begin miscompares++; $display("FAIL seed_data f=%0d got=%h exp=%h", i, q, exp[i]); end
      tick();
      vectors++;
      if (filt_valid !== 1'b0 || filter_ready !== 1'b1 || filt_data !== q) begin
        miscompares++;
        $display("FAIL seed_after f=%0d valid=%b ready=%b data=%h exp valid=0 ready=1 data=%h", i, filt_valid, filter_ready, filt_data, q);
      end
    end
  endtask

  task automatic test_neg_round();
    logic [79:0] q, exp;
    int lat, waited;
    logic rdy_err;
    exp = mk(43, -16'sd1, -16'sd25, -16'sd8192, 0);
    run_frame(mk(43, -16'sd1, -16'sd100, 16'h8000, 0), 0, 0, q, lat, waited, rdy_err);
    vectors++;
    if ((q & MASK) !== (exp & MASK)) begin miscompares++; $display("FAIL neg_round got=%h exp=%h", q, exp); end
  endtask

  task automatic test_clk_en();
    logic [79:0] q, exp;
    int lat, waited;
    logic rdy_err;
    exp = mk(43, -16'sd1, -16'sd25, -16'sd8192, 100);
    run_frame(mk(43, -16'sd1, -16'sd25, -16'sd8192, 400), 2, 0, q, lat, waited, rdy_err);
    vectors++;
    if (lat !== 9) begin miscompares++; $display("FAIL clk_en_latency got=%0d exp=9", lat); end
    vectors++;
    if ((q & MASK) !== (exp & MASK)) begin miscompares++; $display("FAIL clk_en_data got=%h exp=%h", q, exp); end
    tick();
    vectors++;
    if (filt_valid !== 1'b0) begin miscompares++; $display("FAIL clk_en_pulse_width got=%b exp=0", filt_valid); end
  endtask

  task automatic test_reset_mid();
    logic [79:0] din [2];
    logic [79:0] exp [2];
    logic [79:0] q;
    int lat, waited;
    logic rdy_err;
    data_in = mk(1000, 1, 2, 3, 4);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    tick();
    tick();
    n_rst = 1'b0;
    #1;
    vectors++;
    if (filter_ready !== 1'b1 || filt_data !== 80'h0) begin
      miscompares++;
      $display("FAIL mid_reset ready=%b data=%h exp ready=1 data=0", filter_ready, filt_data);
    end
    tick();
    n_rst = 1'b1;
    tick();
    din[0] = mk(200, 7, 7, 7, 7); exp[0] = mk(200, 7, 7, 7, 7);
    din[1] = mk(0, 0, 0, 0, 0);   exp[1] = mk(150, 5, 5, 5, 5);
    for (int i = 0; i < 2; i++) begin
      run_frame(din[i], 0, 0, q, lat, waited, rdy_err);
      vectors++;
      if ((q & MASK) !== (exp[i] & MASK)) begin miscompares++; $display("FAIL reseed f=%0d got=%h exp=%h", i, q, exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [79:0] exp [2];
    logic [79:0] q;
    int lat, waited;
    logic rdy_err;
    exp[0] = mk(150, 41, 41, 41, 41);
    exp[1] = mk(150, 68, 68, 68, 68);
    tick();
    for (int i = 0; i < 2; i++) begin
      run_frame(mk(150, 150, 150, 150, 150), 0, 0, q, lat, waited, rdy_err);
      if (i == 1) begin
        vectors++;
        if (waited !== 1) begin miscompares++; $display("FAIL b2b_spacing got_wait=%0d exp=1", waited); end
      end
      vectors++;
      if (lat !== 6) begin miscompares++; $display("FAIL b2b_latency f=%0d got=%0d exp=6", i, lat); end
      vectors++;
      if ((q & MASK) !== (exp[i] & MASK)) begin miscompares++; $display("FAIL b2b_data f=%0d got=%h exp=%h", i, q, exp[i]); end
    end
  endtask

  task automatic test_drop_busy();
    logic [79:0] q, exp;
    int lat, waited, extra;
    logic rdy_err;
    exp = mk(150, 88, 88, 88, 88);
    run_frame(mk(150, 150, 150, 150, 150), 0, 2, q, lat, waited, rdy_err);
    vectors++;
    if ((q & MASK) !== (exp & MASK)) begin miscompares++; $display("FAIL drop_data got=%h exp=%h", q, exp); end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (filt_valid === 1'b1) extra++;
    end
    vectors++;
    if (extra !== 0) begin miscompares++; $display("FAIL drop_extra_valid got=%0d exp=0", extra); end
  endtask

`ifdef IMU_FILTER_BIAS_EN
  task automatic test_bias();
    logic [79:0] q, exp;
    int lat, waited;
    logic rdy_err;
    logic [15:0] gx, gx_exp;
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
    for (int i = 1; i <= 18; i++) begin
      gx     = (i <= 17) ? 16'd40 : 16'd48;
      gx_exp = (i <= 17) ? 16'd0 : 16'd2;
      exp    = mk(5, 0, 0, gx_exp, 0);
      run_frame(mk(5, 0, 0, gx, -16'sd8), 0, 0, q, lat, waited, rdy_err);
      vectors++;
      if (q !== exp) begin miscompares++; $display("FAIL bias_data f=%0d got=%h exp=%h", i, q, exp); end
      vectors++;
      if (bias_done !== (i >= 16)) begin miscompares++; $display("FAIL bias_done f=%0d got=%b exp=%b", i, bias_done, (i >= 16)); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_seed_step();
    test_neg_round();
    test_clk_en();
    test_reset_mid();
    test_back_to_back();
    test_drop_busy();
`ifdef IMU_FILTER_BIAS_EN
    test_bias();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
